// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered serial transmitter with built-in baud generation.
// Words enter a FIFO over a valid/ready handshake and are serialised
// LSB-first as start / DATA_BITS data / optional parity / 1 or 2 stop bits.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   tx_data      word to transmit
//   tx_valid     tx_data valid this cycle
//   tx_ready     FIFO can accept a word (not full)
//   choose       baud select: 00=9600, 01=19200, 10=57600, 11=115200
//   parity_mode  00=none, 01=even, 10=odd, 11=none
//   stop2        1 = two stop bits, 0 = one stop bit
//   tx_out       serial line, idle high, driven from a flop
//   tx_busy      a frame is in progress
//   tx_stop      one-cycle pulse on the last cycle of the final stop bit
//   fifo_count   words currently buffered
module uart_tx_fifo #(
  parameter int CLK_HZ     = 50000000,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_BITS-1:0]        tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  input  logic [1:0]                  choose,
  input  logic [1:0]                  parity_mode,
  input  logic                        stop2,
  output logic                        tx_out,
  output logic                        tx_busy,
  output logic                        tx_stop,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_HZ / 9600 + 1);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] DIV_9600   = CW'(CLK_HZ / 9600);
  localparam logic [CW-1:0] DIV_19200  = CW'(CLK_HZ / 19200);
  localparam logic [CW-1:0] DIV_57600  = CW'(CLK_HZ / 57600);
  localparam logic [CW-1:0] DIV_115200 = CW'(CLK_HZ / 115200);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  function automatic logic [CW-1:0] baud_div(input logic [1:0] sel);
    case (sel)
      2'b00:   return DIV_9600;
      2'b01:   return DIV_19200;
      2'b10:   return DIV_57600;
      default: return DIV_115200;
    endcase
  endfunction

  function automatic logic parity_on(input logic [1:0] mode);
    return (mode == 2'b01) || (mode == 2'b10);
  endfunction

  // Odd parity is the inverse of the even (XOR) parity.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] w, input logic [1:0] mode);
    return (^w) ^ (mode == 2'b10);
  endfunction

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 push, pop;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt, div_cfg;
  logic [IW-1:0]        idx, idx_nxt;
  logic [DATA_BITS-1:0] sh, sh_nxt;
  logic                 par_en, par_val, stop2_cfg;
  logic                 tx_out_nxt, tx_stop_nxt, bit_end;

  assign tx_ready = (fifo_count != (AW+1)'(FIFO_DEPTH));
  assign push     = tx_valid && tx_ready;
  assign tx_busy  = (state != IDLE);

  // FIFO storage (data only, not reset)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Frame engine: next-state, next line level and pop decision
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + CW'(1);
    idx_nxt    = idx;
    sh_nxt     = sh;
    tx_out_nxt = tx_out;
    pop        = 1'b0;
    bit_end    = (cnt == div_cfg - CW'(1));
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (fifo_count != '0) begin
          pop        = 1'b1;
          sh_nxt     = mem[rd_ptr];
          state_nxt  = START;
          tx_out_nxt = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt  = DATA;
          cnt_nxt    = '0;
          idx_nxt    = '0;
          tx_out_nxt = sh[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_nxt = '0;
          sh_nxt  = sh >> 1;
          if (idx == IW'(DATA_BITS - 1)) begin
            idx_nxt = '0;
            if (par_en) begin
              state_nxt  = PARITY;
              tx_out_nxt = par_val;
            end else begin
              state_nxt  = STOP;
              tx_out_nxt = 1'b1;
            end
          end else begin
            idx_nxt    = idx + IW'(1);
            tx_out_nxt = sh[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nxt  = STOP;
          cnt_nxt    = '0;
          idx_nxt    = '0;
          tx_out_nxt = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_nxt = '0;
          // idx counts stop bits; a second one is only taken with stop2.
          if (stop2_cfg && idx == '0) begin
            idx_nxt = IW'(1);
          end else if (fifo_count != '0) begin
            pop        = 1'b1;
            sh_nxt     = mem[rd_ptr];
            state_nxt  = START;
            tx_out_nxt = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Registered look-ahead so tx_stop is high on the final stop cycle.
    tx_stop_nxt = (state_nxt == STOP) &&
                  (idx_nxt == (stop2_cfg ? IW'(1) : IW'(0))) &&
                  (cnt_nxt == div_cfg - CW'(1));
  end

  // Control registers and frame configuration latched at pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      tx_out    <= 1'b1;
      tx_stop   <= 1'b0;
      par_en    <= 1'b0;
      stop2_cfg <= 1'b0;
      div_cfg   <= DIV_115200;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      tx_out  <= tx_out_nxt;
      tx_stop <= tx_stop_nxt;
      if (pop) begin
        par_en    <= parity_on(parity_mode);
        stop2_cfg <= stop2;
        div_cfg   <= baud_div(choose);
      end
    end
  end

  // Shift register and parity value (data path, not reset)
  always_ff @(posedge clk) begin
    sh <= sh_nxt;
    if (pop) par_val <= parity_bit(mem[rd_ptr], parity_mode);
  end

endmodule
